// File: rtl/vai_serve_tx.sv
// vai_serve_tx: merges sub-AFU CCI-P Tx traffic onto one upstream port with per-VM address rebasing and vmid tagging.
module vai_tx_chan #(
  parameter int N = 8,
  parameter int LN = 3,
  parameter int DEPTH = 8,
  parameter int SLACK = 4,
  parameter int W = 74
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0][W-1:0]  in_entry,
  input  logic [N-1:0][63:0]   offset,
  input  logic                 up_almfull,
  output logic [N-1:0]         almfull,
  output logic                 out_valid,
  output logic [W-1:0]         out_entry,
  output logic                 overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [N][DEPTH];
  logic [N-1:0][PW-1:0] wp, rp;
  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0] push, pop, nonempty;
  logic [LN-1:0] rr, gnt;
  logic gnt_v;
  logic [W-1:0] head, rebased;
  always_comb begin
    for (int n = 0; n < N; n++) begin
      nonempty[n] = cnt[n] != '0;
      almfull[n] = cnt[n] >= CW'(DEPTH - SLACK);
      push[n] = in_valid[n] && cnt[n] != CW'(DEPTH);
    end
  end
  // scan backwards so the last hit is the first non-empty FIFO after rr
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    for (int i = N; i >= 1; i--)
      if (nonempty[LN'(int'(rr) + i)]) begin
        gnt_v = 1'b1;
        gnt = LN'(int'(rr) + i);
      end
    gnt_v = gnt_v && !up_almfull;
    for (int n = 0; n < N; n++) pop[n] = gnt_v && gnt == LN'(n);
    head = mem[gnt][rp[gnt]];
    rebased = head;
    rebased[57:16] = head[57:16] + offset[gnt][41:0];
    rebased[15 -: LN] = gnt;
  end
  always_ff @(posedge clk)
    for (int n = 0; n < N; n++)
      if (push[n]) mem[n][wp[n]] <= in_entry[n];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rr <= LN'(N - 1);
      out_valid <= 1'b0;
      out_entry <= '0;
      overflow <= 1'b0;
    end else begin
      for (int n = 0; n < N; n++) begin
        wp[n] <= wp[n] + PW'(push[n]);
        rp[n] <= rp[n] + PW'(pop[n]);
        cnt[n] <= cnt[n] + CW'(push[n]) - CW'(pop[n]);
      end
      overflow <= overflow | |(in_valid & ~push);
      out_valid <= gnt_v;
      out_entry <= gnt_v ? rebased : '0;
      rr <= gnt_v ? gnt : rr;
    end
endmodule

module vai_serve_tx #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMFULL_SLACK = 4,
  parameter int DATA_W = 512
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_SUB_AFUS-1:0]                afu_c0_valid,
  input  logic [NUM_SUB_AFUS-1:0][73:0]          afu_c0_hdr,
  input  logic [NUM_SUB_AFUS-1:0]                afu_c1_valid,
  input  logic [NUM_SUB_AFUS-1:0][79:0]          afu_c1_hdr,
  input  logic [NUM_SUB_AFUS-1:0][DATA_W-1:0]    afu_c1_data,
  input  logic [NUM_SUB_AFUS-1:0]                afu_c2_mmio_rd_valid,
  input  logic [NUM_SUB_AFUS-1:0][8:0]           afu_c2_hdr,
  input  logic [NUM_SUB_AFUS-1:0][63:0]          afu_c2_data,
  output logic [NUM_SUB_AFUS-1:0]                afu_c0_tx_almfull,
  output logic [NUM_SUB_AFUS-1:0]                afu_c1_tx_almfull,
  input  logic [NUM_SUB_AFUS-1:0][63:0]          offset_array,
  input  logic                                   up_c0_tx_almfull,
  input  logic                                   up_c1_tx_almfull,
  output logic                                   up_c0_valid,
  output logic [73:0]                            up_c0_hdr,
  output logic                                   up_c1_valid,
  output logic [79:0]                            up_c1_hdr,
  output logic [DATA_W-1:0]                      up_c1_data,
  output logic                                   up_c2_mmio_rd_valid,
  output logic [8:0]                             up_c2_hdr,
  output logic [63:0]                            up_c2_data,
  output logic                                   err_overflow
);
  localparam int N = NUM_SUB_AFUS;
  localparam int LN = $clog2(N);
  logic [N-1:0][DATA_W+79:0] c1_in;
  logic c0_ovf, c1_ovf;
  logic [8:0] c2_hdr;
  logic [63:0] c2_data;
  always_comb
    for (int n = 0; n < N; n++) c1_in[n] = {afu_c1_data[n], afu_c1_hdr[n]};
  vai_tx_chan #(.N(N), .LN(LN), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK), .W(74)) u_c0 (
    .clk(clk), .reset(reset), .in_valid(afu_c0_valid), .in_entry(afu_c0_hdr),
    .offset(offset_array), .up_almfull(up_c0_tx_almfull), .almfull(afu_c0_tx_almfull),
    .out_valid(up_c0_valid), .out_entry(up_c0_hdr), .overflow(c0_ovf)
  );
  vai_tx_chan #(.N(N), .LN(LN), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK), .W(DATA_W + 80)) u_c1 (
    .clk(clk), .reset(reset), .in_valid(afu_c1_valid), .in_entry(c1_in),
    .offset(offset_array), .up_almfull(up_c1_tx_almfull), .almfull(afu_c1_tx_almfull),
    .out_valid(up_c1_valid), .out_entry({up_c1_data, up_c1_hdr}), .overflow(c1_ovf)
  );
  assign err_overflow = c0_ovf | c1_ovf;
  // only one MMIO read can be outstanding, so the lowest requester simply wins
  always_comb begin
    c2_hdr = '0;
    c2_data = '0;
    for (int n = N - 1; n >= 0; n--)
      if (afu_c2_mmio_rd_valid[n]) begin
        c2_hdr = afu_c2_hdr[n];
        c2_data = afu_c2_data[n];
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      up_c2_mmio_rd_valid <= 1'b0;
      up_c2_hdr <= '0;
      up_c2_data <= '0;
    end else begin
      up_c2_mmio_rd_valid <= |afu_c2_mmio_rd_valid;
      up_c2_hdr <= c2_hdr;
      up_c2_data <= c2_data;
    end
endmodule

// File: tb/tb_vai_serve_tx.sv
// tb_vai_serve_tx: vector table plus scoreboarded corner sequences for vai_serve_tx.
module tb_vai_serve_tx;
  localparam int N = 8;
  localparam int DW = 512;
  typedef struct {
    logic [79:0]   hdr;
    logic [DW-1:0] data;
  } exp_t;
  typedef struct {
    bit          ch;
    int          afu;
    logic [41:0] addr;
    logic [15:0] md;
    logic [63:0] off;
    logic [41:0] eaddr;
    logic [15:0] emd;
  } vec_t;
  logic clk = 0, reset = 1;
  logic [N-1:0] afu_c0_valid = '0, afu_c1_valid = '0, afu_c2_mmio_rd_valid = '0;
  logic [N-1:0][73:0] afu_c0_hdr = '0;
  logic [N-1:0][79:0] afu_c1_hdr = '0;
  logic [N-1:0][DW-1:0] afu_c1_data = '0;
  logic [N-1:0][8:0] afu_c2_hdr = '0;
  logic [N-1:0][63:0] afu_c2_data = '0;
  logic [N-1:0][63:0] offset_array = '0;
  logic [N-1:0] afu_c0_tx_almfull, afu_c1_tx_almfull;
  logic up_c0_tx_almfull = 0, up_c1_tx_almfull = 0;
  logic up_c0_valid, up_c1_valid, up_c2_mmio_rd_valid, err_overflow;
  logic [73:0] up_c0_hdr;
  logic [79:0] up_c1_hdr;
  logic [DW-1:0] up_c1_data;
  logic [8:0] up_c2_hdr;
  logic [63:0] up_c2_data;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  vec_t vecs[6];
  vec_t v;
  logic [DW-1:0] d;
  int checks = 0, errors = 0;

  vai_serve_tx dut (
    .clk(clk), .reset(reset),
    .afu_c0_valid(afu_c0_valid), .afu_c0_hdr(afu_c0_hdr),
    .afu_c1_valid(afu_c1_valid), .afu_c1_hdr(afu_c1_hdr), .afu_c1_data(afu_c1_data),
    .afu_c2_mmio_rd_valid(afu_c2_mmio_rd_valid), .afu_c2_hdr(afu_c2_hdr), .afu_c2_data(afu_c2_data),
    .afu_c0_tx_almfull(afu_c0_tx_almfull), .afu_c1_tx_almfull(afu_c1_tx_almfull),
    .offset_array(offset_array),
    .up_c0_tx_almfull(up_c0_tx_almfull), .up_c1_tx_almfull(up_c1_tx_almfull),
    .up_c0_valid(up_c0_valid), .up_c0_hdr(up_c0_hdr),
    .up_c1_valid(up_c1_valid), .up_c1_hdr(up_c1_hdr), .up_c1_data(up_c1_data),
    .up_c2_mmio_rd_valid(up_c2_mmio_rd_valid), .up_c2_hdr(up_c2_hdr), .up_c2_data(up_c2_data),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] mkhdr(input bit ch, input logic [41:0] a, input logic [15:0] md);
    return ch ? {22'h1BEEF5, a, md} : {6'b0, 16'hC0DE, a, md};
  endfunction

  function automatic logic [15:0] tag(input int afu, input logic [15:0] md);
    logic [2:0] t;
    t = 3'(afu);
    return {t, md[12:0]};
  endfunction

  task automatic send(input bit ch, input int afu, input logic [41:0] a, input logic [15:0] md, input logic [DW-1:0] dat);
    logic [79:0] h;
    h = mkhdr(ch, a, md);
    if (ch) begin
      afu_c1_valid[afu] = 1'b1;
      afu_c1_hdr[afu] = h;
      afu_c1_data[afu] = dat;
    end else begin
      afu_c0_valid[afu] = 1'b1;
      afu_c0_hdr[afu] = h[73:0];
    end
  endtask

  task automatic idle();
    afu_c0_valid = '0;
    afu_c1_valid = '0;
    afu_c2_mmio_rd_valid = '0;
  endtask

  always @(negedge clk) if (!reset) begin
    if (up_c0_valid) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c0_unexpected: got hdr %0h expected no request", up_c0_hdr);
      end else begin
        e0 = q0.pop_front();
        chk("c0_hdr", DW'(up_c0_hdr), DW'(e0.hdr));
      end
    end
    if (up_c1_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c1_unexpected: got hdr %0h expected no request", up_c1_hdr);
      end else begin
        e1 = q1.pop_front();
        chk("c1_hdr", DW'(up_c1_hdr), DW'(e1.hdr));
        chk("c1_data", up_c1_data, e1.data);
      end
    end
  end

  initial begin
    vecs[0] = '{0, 3, 42'h100, 16'h0012, 64'h4000, 42'h4100, 16'h6012};
    vecs[1] = '{1, 0, 42'h3FF_FFFF_FFF0, 16'hFFFF, 64'h20, 42'h10, 16'h1FFF};
    vecs[2] = '{0, 7, 42'h123, 16'h0000, 64'h0, 42'h123, 16'hE000};
    vecs[3] = '{1, 2, 42'h1000, 16'hABCD, 64'hFFFF_FFFF_FFFF_F000, 42'h0, 16'h4BCD};
    vecs[4] = '{0, 1, 42'h2AA, 16'hE001, 64'h1, 42'h2AB, 16'h2001};
    vecs[5] = '{1, 6, 42'h0, 16'h1234, 64'h3FF_FFFF_FFFF, 42'h3FF_FFFF_FFFF, 16'hD234};
    repeat (3) @(negedge clk);
    chk("rst_c0_valid", DW'(up_c0_valid), 0);
    chk("rst_c1_valid", DW'(up_c1_valid), 0);
    chk("rst_c2_valid", DW'(up_c2_mmio_rd_valid), 0);
    chk("rst_ovf", DW'(err_overflow), 0);
    chk("rst_almfull", DW'({afu_c0_tx_almfull, afu_c1_tx_almfull}), 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_c1_hdr", DW'(up_c1_hdr), 0);
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      offset_array[v.afu] = v.off;
      d = {16{$urandom()}};
      send(v.ch, v.afu, v.addr, v.md, d);
      if (v.ch) q1.push_back('{mkhdr(1, v.eaddr, v.emd), d});
      else q0.push_back('{mkhdr(0, v.eaddr, v.emd), '0});
      @(negedge clk);
      idle();
      chk("lat_early", DW'(v.ch ? up_c1_valid : up_c0_valid), 0);
      @(negedge clk);
      chk("lat_valid", DW'(v.ch ? up_c1_valid : up_c0_valid), 1);
      @(negedge clk);
    end
    // contention: one cycle of c1 writes from AFUs 0,2,5, then a 0,2 round
    offset_array[0] = '0;
    offset_array[2] = '0;
    offset_array[5] = '0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3 - r; k++) begin
        automatic int a = (k == 0) ? 0 : (k == 1) ? 2 : 5;
        d = {16{$urandom()}};
        send(1, a, 42'(32'h300 + 32'(r * 16 + a)), 16'(16'h0040 + 16'(a)), d);
        q1.push_back('{mkhdr(1, 42'(32'h300 + 32'(r * 16 + a)), tag(a, 16'(16'h0040 + 16'(a)))), d});
      end
      @(negedge clk);
      idle();
      for (int k = 0; k < 3 - r; k++) begin
        @(negedge clk);
        chk("cont_valid", DW'(up_c1_valid), 1);
      end
    end
    @(negedge clk);
    chk("cont_done", DW'(up_c1_valid), 0);
    afu_c2_mmio_rd_valid[4] = 1'b1;
    afu_c2_hdr[4] = 9'h1A4;
    afu_c2_data[4] = 64'hDEAD_BEEF_0000_0004;
    afu_c2_mmio_rd_valid[6] = 1'b1;
    afu_c2_hdr[6] = 9'h066;
    afu_c2_data[6] = 64'h1111_2222_3333_0006;
    @(negedge clk);
    idle();
    chk("c2_valid", DW'(up_c2_mmio_rd_valid), 1);
    chk("c2_hdr", DW'(up_c2_hdr), DW'(9'h1A4));
    chk("c2_data", DW'(up_c2_data), DW'(64'hDEAD_BEEF_0000_0004));
    @(negedge clk);
    chk("c2_idle", DW'(up_c2_mmio_rd_valid), 0);
    // backpressure fills AFU1 c0, ninth write overflows
    up_c0_tx_almfull = 1'b1;
    offset_array[1] = '0;
    for (int k = 0; k < 8; k++) begin
      send(0, 1, 42'(32'h200 + 32'(k)), 16'(16'h0100 + 16'(k)), '0);
      q0.push_back('{mkhdr(0, 42'(32'h200 + 32'(k)), tag(1, 16'(16'h0100 + 16'(k)))), '0});
      @(negedge clk);
      chk("bp_almfull", DW'(afu_c0_tx_almfull[1]), DW'(k + 1 >= 4));
      chk("bp_no_valid", DW'(up_c0_valid), 0);
    end
    chk("ovf_before", DW'(err_overflow), 0);
    send(0, 1, 42'h2FF, 16'h01FF, '0);
    @(negedge clk);
    idle();
    chk("ovf_set", DW'(err_overflow), 1);
    up_c0_tx_almfull = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("drain_valid", DW'(up_c0_valid), 1);
    end
    @(negedge clk);
    chk("drain_done", DW'(up_c0_valid), 0);
    chk("drain_almfull", DW'(afu_c0_tx_almfull[1]), 0);
    chk("ovf_sticky", DW'(err_overflow), 1);
    // async reset with queued requests in flight
    up_c1_tx_almfull = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(1, 0, 42'(32'h500 + 32'(k)), 16'h0, '0);
      @(negedge clk);
    end
    idle();
    chk("pre_rst_almfull", DW'(afu_c1_tx_almfull[0]), 1);
    offset_array[3] = '0;
    send(0, 3, 42'h777, 16'h0005, '0);
    q0.push_back('{mkhdr(0, 42'h777, tag(3, 16'h0005)), '0});
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("pre_rst_valid", DW'(up_c0_valid), 1);
    #2 reset = 1;
    #1;
    chk("arst_c0_valid", DW'(up_c0_valid), 0);
    chk("arst_c0_hdr", DW'(up_c0_hdr), 0);
    chk("arst_almfull", DW'(afu_c1_tx_almfull), 0);
    chk("arst_ovf", DW'(err_overflow), 0);
    @(negedge clk);
    reset = 0;
    up_c1_tx_almfull = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_stale_c1", DW'(up_c1_valid), 0);
    end
    chk("q0_empty", DW'(q0.size()), 0);
    chk("q1_empty", DW'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
